block_plot_engine: RTL and testbench
====================================

Name: block_plot_engine

Overview:
- Pixel-writer stage directly downstream of the block-position logic.
- Converts a "block moved to (x,y)" request into a stream of single-pixel writes on the 160x120 framebuffer plot interface (vga_x/vga_y/vga_colour/vga_plot).
- Erases the block at its previous position, then draws it at the new one, one pixel per clock.
- After reset, clears the whole screen before accepting moves.

Parameters:
- BLK_W, 8, block width in pixels (1..SCR_W).
- BLK_H, 8, block height in pixels (1..SCR_H).
- SCR_W, 160, screen width; vga_x range 0..SCR_W-1.
- SCR_H, 120, screen height; vga_y range 0..SCR_H-1.
- BG_COLOUR, 3'b000, colour used for screen clear and erase.
- CLEAR_ON_RESET, 1, 1 = full-screen clear after reset; 0 = go straight to IDLE.

Ports:
- clk  input  1  system clock (50 MHz domain).
- rst  input  1  synchronous, active-high reset.
- move_req  input  1  one-cycle request; samples new_x/new_y/blk_colour in the same cycle.
- new_x  input  8  requested block left column.
- new_y  input  7  requested block top row.
- blk_colour  input  3  block colour {R,G,B}.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse after the last draw pixel of a move.
- vga_x  output  8  pixel column.
- vga_y  output  7  pixel row.
- vga_colour  output  3  pixel colour.
- vga_plot  output  1  write strobe; x/y/colour are valid only when high.

Behaviour:
- Reset (rst high at a clk edge):
  - Registered outputs go to: vga_plot=0, vga_x=0, vga_y=0, vga_colour=BG_COLOUR, done=0.
  - has_old=0, pending=0.
  - State goes to CLEAR if CLEAR_ON_RESET, else IDLE; busy follows state.
  - Reset mid-operation aborts the current operation immediately; no further plots from it.
- States: CLEAR, IDLE, ERASE, DRAW, FIN.
- CLEAR:
  - Raster sweep, x fastest, over (0,0)..(SCR_W-1,SCR_H-1) with BG_COLOUR.
  - One plot per cycle, SCR_W*SCR_H plots total.
  - After the last pixel, goes to IDLE; no done pulse.
- Request capture:
  - move_req in IDLE: inputs are latched and the state goes to ERASE if has_old, else DRAW.
  - First vga_plot appears on the next cycle.
  - move_req while busy: latched into a single pending slot, latest request wins; earlier pending requests are lost.
- Clamping, applied at capture:
  - x = min(new_x, SCR_W-BLK_W).
  - y = min(new_y, SCR_H-BLK_H).
  - The block is never written off-screen.
- ERASE:
  - Raster over the old rectangle (old_x..old_x+BLK_W-1, old_y..old_y+BLK_H-1) with BG_COLOUR.
  - BLK_W*BLK_H consecutive plots, then DRAW with no gap cycle.
- DRAW:
  - Raster over the new rectangle with the latched colour.
  - BLK_W*BLK_H consecutive plots.
  - On the last pixel: old_x/old_y := new position, has_old := 1, go to FIN.
- FIN (one cycle):
  - done=1, vga_plot=0.
  - If pending: consume it and go to ERASE on the next cycle; busy stays high and no IDLE cycle occurs.
  - Otherwise go to IDLE.
- Same-position or colour-only move still performs the full erase and redraw.
- Latency:
  - Move with has_old: 2*BLK_W*BLK_H plot cycles, then 1 FIN cycle.
  - First move after reset: BLK_W*BLK_H plot cycles, then 1 FIN cycle.
- vga_plot is high on exactly the pixel cycles; it is low in IDLE and FIN.
- Counters:
  - x/y counters are sized to the parameters; no wrap beyond rectangle bounds.
  - Arithmetic is unsigned; x/y sums are computed one bit wider before truncation to the port width.

Test Plan:
1. Reset, CLEAR_ON_RESET=1: release rst -> exactly 19200 plots, colour 000, first (0,0), last (159,119), busy falls the next cycle, no done pulse.
2. From IDLE, move_req with (10,20), colour 3'b100:
   - No erase; 64 plots of 100 at x 10..17, y 20..27, in raster order.
   - done pulses one cycle after the last plot; busy falls with FIN exit.
3. Then move_req (12,21), colour 3'b010:
   - 64 erase plots of 000 over (10..17, 20..27).
   - Then, with no gap, 64 plots of 010 over (12..19, 21..28).
   - 129 busy cycles total.
4. move_req (200,127) -> drawn at clamped (152,112); last pixel (159,119); no coordinate exceeds the screen.
5. During a draw, issue move_req (30,30) then (40,50) -> only (40,50) is serviced, directly after FIN; erase targets the previous block.
6. Assert rst midway through DRAW -> vga_plot=0 the next cycle, CLEAR restarts, and the next move skips erase (has_old=0).

Source files
------------

// File: rtl/block_plot_engine.sv
// rtl/block_plot_engine.sv - erases and redraws a solid block on the framebuffer plot interface, one pixel per clock
// The registered outputs always show the pixel for the current state and counters; clear_arm_q covers the idle cycle after reset.
module block_plot_engine #(
    parameter int       BLK_W          = 8,
    parameter int       BLK_H          = 8,
    parameter int       SCR_W          = 160,
    parameter int       SCR_H          = 120,
    parameter logic [2:0] BG_COLOUR    = 3'b000,
    parameter bit       CLEAR_ON_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       move_req,
    input  logic [7:0] new_x,
    input  logic [6:0] new_y,
    input  logic [2:0] blk_colour,
    output logic       busy,
    output logic       done,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);
    typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_ERASE, S_DRAW, S_FIN} state_t;

    localparam logic [7:0] MAX_X  = 8'(SCR_W - BLK_W);
    localparam logic [6:0] MAX_Y  = 7'(SCR_H - BLK_H);
    localparam logic [7:0] BW_M1  = 8'(BLK_W - 1);
    localparam logic [6:0] BH_M1  = 7'(BLK_H - 1);
    localparam logic [7:0] SW_M1  = 8'(SCR_W - 1);
    localparam logic [6:0] SH_M1  = 7'(SCR_H - 1);

    state_t     state_q, state_d;
    logic       clear_arm_q, clear_arm_d;
    logic [7:0] cx_q, cx_d;
    logic [6:0] cy_q, cy_d;
    logic [7:0] cur_x_q, cur_x_d, old_x_q, old_x_d, pend_x_q, pend_x_d;
    logic [6:0] cur_y_q, cur_y_d, old_y_q, old_y_d, pend_y_q, pend_y_d;
    logic [2:0] cur_c_q, cur_c_d, pend_c_q, pend_c_d;
    logic       has_old_q, has_old_d, pend_q, pend_d;
    logic       plot_q, plot_d, done_q, done_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] col_q, col_d;

    logic [7:0] cap_x, x_lim, base_x;
    logic [6:0] cap_y, y_lim, base_y;
    logic       row_end, last, req_any;
    logic [8:0] sum_x;
    logic [7:0] sum_y;

    // Clamping happens at capture so both live and pending requests stay on screen.
    assign cap_x   = (new_x > MAX_X) ? MAX_X : new_x;
    assign cap_y   = (new_y > MAX_Y) ? MAX_Y : new_y;
    assign req_any = move_req || pend_q;

    always_comb begin
        state_d     = state_q;
        clear_arm_d = clear_arm_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        cur_c_d     = cur_c_q;
        old_x_d     = old_x_q;
        old_y_d     = old_y_q;
        has_old_d   = has_old_q;
        pend_d      = pend_q;
        pend_x_d    = pend_x_q;
        pend_y_d    = pend_y_q;
        pend_c_d    = pend_c_q;

        x_lim   = (state_q == S_CLEAR) ? SW_M1 : BW_M1;
        y_lim   = (state_q == S_CLEAR) ? SH_M1 : BH_M1;
        row_end = (cx_q == x_lim);
        last    = row_end && (cy_q == y_lim);

        if (move_req && state_q != S_IDLE && state_q != S_FIN) begin
            pend_d   = 1'b1;
            pend_x_d = cap_x;
            pend_y_d = cap_y;
            pend_c_d = blk_colour;
        end

        case (state_q)
            S_CLEAR: begin
                if (clear_arm_q) begin
                    clear_arm_d = 1'b0;
                end else if (last) begin
                    state_d = S_IDLE;
                end else if (row_end) begin
                    cx_d = 8'd0;
                    cy_d = cy_q + 7'd1;
                end else begin
                    cx_d = cx_q + 8'd1;
                end
            end
            S_IDLE, S_FIN: begin
                state_d = S_IDLE;
                if (req_any) begin
                    // A live request in the same cycle is newer than anything pending.
                    cur_x_d = move_req ? cap_x : pend_x_q;
                    cur_y_d = move_req ? cap_y : pend_y_q;
                    cur_c_d = move_req ? blk_colour : pend_c_q;
                    pend_d  = 1'b0;
                    cx_d    = 8'd0;
                    cy_d    = 7'd0;
                    state_d = has_old_q ? S_ERASE : S_DRAW;
                end
            end
            S_ERASE, S_DRAW: begin
                if (last) begin
                    cx_d = 8'd0;
                    cy_d = 7'd0;
                    if (state_q == S_ERASE) begin
                        state_d = S_DRAW;
                    end else begin
                        old_x_d   = cur_x_q;
                        old_y_d   = cur_y_q;
                        has_old_d = 1'b1;
                        state_d   = S_FIN;
                    end
                end else if (row_end) begin
                    cx_d = 8'd0;
                    cy_d = cy_q + 7'd1;
                end else begin
                    cx_d = cx_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Output registers are loaded with the pixel belonging to the next state.
        plot_d = (state_d == S_ERASE) || (state_d == S_DRAW) ||
                 (state_d == S_CLEAR && !clear_arm_d);
        base_x = (state_d == S_ERASE) ? old_x_d : (state_d == S_DRAW) ? cur_x_d : 8'd0;
        base_y = (state_d == S_ERASE) ? old_y_d : (state_d == S_DRAW) ? cur_y_d : 7'd0;
        sum_x  = {1'b0, base_x} + {1'b0, cx_d};
        sum_y  = {1'b0, base_y} + {1'b0, cy_d};
        x_d    = plot_d ? sum_x[7:0] : x_q;
        y_d    = plot_d ? sum_y[6:0] : y_q;
        col_d  = plot_d ? ((state_d == S_DRAW) ? cur_c_d : BG_COLOUR) : col_q;
        done_d = (state_d == S_FIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
            clear_arm_q <= 1'b1;
            cx_q        <= 8'd0;
            cy_q        <= 7'd0;
            cur_x_q     <= 8'd0;
            cur_y_q     <= 7'd0;
            cur_c_q     <= 3'd0;
            old_x_q     <= 8'd0;
            old_y_q     <= 7'd0;
            has_old_q   <= 1'b0;
            pend_q      <= 1'b0;
            pend_x_q    <= 8'd0;
            pend_y_q    <= 7'd0;
            pend_c_q    <= 3'd0;
            plot_q      <= 1'b0;
            x_q         <= 8'd0;
            y_q         <= 7'd0;
            col_q       <= BG_COLOUR;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            clear_arm_q <= clear_arm_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            cur_c_q     <= cur_c_d;
            old_x_q     <= old_x_d;
            old_y_q     <= old_y_d;
            has_old_q   <= has_old_d;
            pend_q      <= pend_d;
            pend_x_q    <= pend_x_d;
            pend_y_q    <= pend_y_d;
            pend_c_q    <= pend_c_d;
            plot_q      <= plot_d;
            x_q         <= x_d;
            y_q         <= y_d;
            col_q       <= col_d;
            done_q      <= done_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign vga_plot   = plot_q;
    assign vga_x      = x_q;
    assign vga_y      = y_q;
    assign vga_colour = col_q;
endmodule

// File: tb/tb_block_plot_engine.sv
// tb/tb_block_plot_engine.sv - scoreboard bench for block_plot_engine: clear, moves, clamping, pending and reset abort
module tb_block_plot_engine;
    logic       clk, rst, move_req, busy, done, vga_plot;
    logic [7:0] new_x, vga_x;
    logic [6:0] new_y, vga_y;
    logic [2:0] blk_colour, vga_colour;

    typedef struct packed {
        logic       is_done;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } ev_t;

    ev_t q[$];
    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 0;

    block_plot_engine dut (
        .clk(clk), .rst(rst), .move_req(move_req), .new_x(new_x), .new_y(new_y),
        .blk_colour(blk_colour), .busy(busy), .done(done), .vga_x(vga_x),
        .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every plot or done pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (mon_en && (vga_plot || done)) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: plot=%0b done=%0b x=%0d y=%0d c=%0d, expected nothing",
                         vga_plot, done, vga_x, vga_y, vga_colour);
            end else begin
                ev_t e;
                e = q.pop_front();
                if (e.is_done != done || e.is_done == vga_plot ||
                    (vga_plot && (vga_x != e.x || vga_y != e.y || vga_colour != e.c))) begin
                    errors++;
                    $display("FAIL pixel_stream: got plot=%0b done=%0b (%0d,%0d) c=%0d, expected done=%0b (%0d,%0d) c=%0d",
                             vga_plot, done, vga_x, vga_y, vga_colour, e.is_done, e.x, e.y, e.c);
                end
            end
            if (vga_plot) begin
                checks++;
                if (vga_x >= 8'd160 || vga_y >= 7'd120) begin
                    errors++;
                    $display("FAIL on_screen: got (%0d,%0d), required x<160 y<120", vga_x, vga_y);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_rect(input int x0, input int y0, input int c, input int w, input int h, input int n);
        int k = 0;
        for (int yy = 0; yy < h; yy++)
            for (int xx = 0; xx < w; xx++) begin
                if (k < n) q.push_back({1'b0, 8'(x0 + xx), 7'(y0 + yy), 3'(c)});
                k++;
            end
    endtask

    task automatic push_blk(input int x0, input int y0, input int c);
        push_rect(x0, y0, c, 8, 8, 64);
    endtask

    task automatic push_done();
        q.push_back({1'b1, 8'd0, 7'd0, 3'd0});
    endtask

    task automatic wait_empty(input string name, input int lim);
        int n = 0;
        while (q.size() != 0 && n < lim) begin
            tick();
            n++;
        end
        chk(name, q.size(), 0);
    endtask

    task automatic issue(input int x, input int y, input int c);
        new_x      = 8'(x);
        new_y      = 7'(y);
        blk_colour = 3'(c);
        move_req   = 1'b1;
        tick();
        move_req   = 1'b0;
    endtask

    task automatic do_move(input string name, input int x, input int y, input int c, input int exp_busy);
        int nb = 0;
        issue(x, y, c);
        while (busy && nb < 5000) begin
            nb++;
            tick();
        end
        chk({name, "_busy_cycles"}, nb, exp_busy);
        chk({name, "_drained"}, q.size(), 0);
    endtask

    initial begin
        int nb;
        rst = 1'b1; move_req = 1'b0; new_x = '0; new_y = '0; blk_colour = '0;
        tick();
        tick();
        mon_en = 1'b1;
        chk("rst_plot", vga_plot, 0);
        chk("rst_x", vga_x, 0);
        chk("rst_y", vga_y, 0);
        chk("rst_colour", vga_colour, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 1);

        // Full-screen clear after reset release
        push_rect(0, 0, 0, 160, 120, 19200);
        rst = 1'b0;
        wait_empty("clear_drain", 20000);
        chk("clear_busy_after", busy, 0);
        chk("clear_plot_after", vga_plot, 0);

        // First move: draw only
        push_blk(10, 20, 3'b100); push_done();
        do_move("first_move", 10, 20, 3'b100, 65);

        // Erase then draw
        push_blk(10, 20, 0); push_blk(12, 21, 3'b010); push_done();
        do_move("second_move", 12, 21, 3'b010, 129);

        // Clamped to (152,112)
        push_blk(12, 21, 0); push_blk(152, 112, 3'b101); push_done();
        do_move("clamp_move", 200, 127, 3'b101, 129);

        // Two requests during a draw: only the latest survives
        push_blk(152, 112, 0); push_blk(60, 40, 3'b001); push_done();
        push_blk(60, 40, 0); push_blk(40, 50, 3'b110); push_done();
        issue(60, 40, 3'b001);
        nb = 0;
        while (busy && nb < 5000) begin
            nb++;
            if (nb == 70) begin
                new_x = 8'd30; new_y = 7'd30; blk_colour = 3'b011; move_req = 1'b1;
            end else if (nb == 80) begin
                new_x = 8'd40; new_y = 7'd50; blk_colour = 3'b110; move_req = 1'b1;
            end else begin
                move_req = 1'b0;
            end
            tick();
        end
        move_req = 1'b0;
        chk("pending_busy_cycles", nb, 258);
        chk("pending_drained", q.size(), 0);

        // Reset in the middle of a draw
        push_blk(40, 50, 0); push_rect(5, 5, 3'b111, 8, 8, 20);
        issue(5, 5, 3'b111);
        repeat (83) tick();
        rst = 1'b1;
        tick();
        chk("abort_plot", vga_plot, 0);
        chk("abort_busy", busy, 1);
        chk("abort_done", done, 0);
        chk("abort_drained", q.size(), 0);
        push_rect(0, 0, 0, 160, 120, 19200);
        rst = 1'b0;
        wait_empty("reclear_drain", 20000);
        chk("reclear_busy_after", busy, 0);

        // has_old cleared by reset: no erase
        push_blk(0, 0, 3'b111); push_done();
        do_move("post_reset_move", 0, 0, 3'b111, 65);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
